// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch resolve unit
package branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    localparam logic [1:0] BHT_RESET_VAL = 2'b01;
    localparam int         PC_STEP       = 4;

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// rtl/branch_bht.sv - direct-mapped 2-bit saturating branch history table
module branch_bht
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d [DEPTH];

    // Reads come straight from the flops, so a same-cycle update is not visible.
    assign rd_taken = cnt_q[rd_idx][1];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = bht_next(cnt_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= BHT_RESET_VAL;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch resolve stage with BHT training
// Optional perf counters enabled by defining BRANCH_PERF_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [2:0]      br_op,
    input  logic            pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mispredict,
    output logic            illegal_op,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic [31:0]     perf_resolved,
    output logic [31:0]     perf_mispredict
);

    logic                 valid_q, valid_d;
    logic                 taken_q, taken_d;
    logic                 mispredict_q, mispredict_d;
    logic                 illegal_q, illegal_d;
    logic [XLEN-1:0]      target_q, target_d;
    logic [XLEN-1:0]      redirect_q, redirect_d;
    logic [BHT_IDX_W-1:0] idx_q, idx_d;

    logic accept;
    logic commit;
    logic cmp_taken;
    logic cmp_illegal;
    logic [XLEN-1:0] sum_target;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign commit   = valid_q && out_ready && !flush;

    always_comb begin
        cmp_taken   = 1'b0;
        cmp_illegal = 1'b0;
        case (br_op)
            BR_BEQ:  cmp_taken = (operand_a == operand_b);
            BR_BNE:  cmp_taken = (operand_a != operand_b);
            BR_BLT:  cmp_taken = ($signed(operand_a) < $signed(operand_b));
            BR_BGE:  cmp_taken = ($signed(operand_a) >= $signed(operand_b));
            BR_BLTU: cmp_taken = (operand_a < operand_b);
            BR_BGEU: cmp_taken = (operand_a >= operand_b);
            default: cmp_illegal = 1'b1;
        endcase
    end

    assign sum_target = pc + imm;

    always_comb begin
        valid_d      = valid_q;
        taken_d      = taken_q;
        mispredict_d = mispredict_q;
        illegal_d    = illegal_q;
        target_d     = target_q;
        redirect_d   = redirect_q;
        idx_d        = idx_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            taken_d      = cmp_taken;
            mispredict_d = cmp_taken != pred_taken;
            illegal_d    = cmp_illegal;
            target_d     = sum_target;
            redirect_d   = cmp_taken ? sum_target : pc + XLEN'(PC_STEP);
            idx_d        = pc[BHT_IDX_W+1:2];
        end else if (commit) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            target_q     <= '0;
            redirect_q   <= '0;
            idx_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            target_q     <= target_d;
            redirect_q   <= redirect_d;
            idx_q        <= idx_d;
        end
    end

    assign out_valid   = valid_q;
    assign taken       = taken_q;
    assign mispredict  = mispredict_q;
    assign illegal_op  = illegal_q;
    assign target      = target_q;
    assign redirect_pc = redirect_q;

    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lookup_pc[BHT_IDX_W+1:2]),
        .rd_taken (lookup_taken),
        .wr_en    (commit && !illegal_q),
        .wr_idx   (idx_q),
        .wr_taken (taken_q)
    );

    // Only the index slice of the fetch PC matters for a direct-mapped table.
    logic unused_lookup_bits;
    assign unused_lookup_bits = &{1'b0, lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0]};

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_res_q, perf_res_d;
    logic [31:0] perf_mis_q, perf_mis_d;

    always_comb begin
        perf_res_d = perf_res_q;
        perf_mis_d = perf_mis_q;
        if (commit) begin
            if (perf_res_q != 32'hFFFF_FFFF) begin
                perf_res_d = perf_res_q + 32'd1;
            end
            if (mispredict_q && perf_mis_q != 32'hFFFF_FFFF) begin
                perf_mis_d = perf_mis_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_res_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_res_q <= perf_res_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_resolved   = perf_res_q;
    assign perf_mispredict = perf_mis_q;
`else
    assign perf_resolved   = 32'd0;
    assign perf_mispredict = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [2:0]  br_op;
    logic        pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] target;
    logic [31:0] redirect_pc;
    logic        mispredict;
    logic        illegal_op;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [31:0] perf_resolved;
    logic [31:0] perf_mispredict;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pc              (pc),
        .imm             (imm),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .br_op           (br_op),
        .pred_taken      (pred_taken),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .taken           (taken),
        .target          (target),
        .redirect_pc     (redirect_pc),
        .mispredict      (mispredict),
        .illegal_op      (illegal_op),
        .lookup_pc       (lookup_pc),
        .lookup_taken    (lookup_taken),
        .perf_resolved   (perf_resolved),
        .perf_mispredict (perf_mispredict)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic pr);
        br_op      = op;
        operand_a  = a;
        operand_b  = b;
        pc         = p;
        imm        = im;
        pred_taken = pr;
        in_valid   = 1'b1;
    endtask

    task automatic look(input string tag, input logic [31:0] lpc, input logic exp);
        lookup_pc = lpc;
        #1;
        check(tag, lookup_taken, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pc = '0; imm = '0; operand_a = '0; operand_b = '0; br_op = 3'b000;
        pred_taken = 1'b0; lookup_pc = 32'h40;
        #12;
        check("rst_taken", taken, 1'b0);
        check("rst_mispredict", mispredict, 1'b0);
        check("rst_illegal", illegal_op, 1'b0);
        check("rst_target", target, 32'h0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_lookup", lookup_taken, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Signed vs unsigned compare, back to back
        issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'd16, 1'b1);
        tick();
        check("blt_valid", out_valid, 1'b1);
        check("blt_taken", taken, 1'b1);
        check("blt_misp", mispredict, 1'b0);
        check("blt_target", target, 32'h210);
        check("blt_redirect", redirect_pc, 32'h210);
        issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'd16, 1'b1);
        tick();
        check("bltu_taken", taken, 1'b0);
        check("bltu_misp", mispredict, 1'b1);
        check("bltu_redirect", redirect_pc, 32'h204);
        issue(3'b000, 32'd5, 32'd5, 32'd100, 32'hFFFF_FFF8, 1'b0);
        tick();
        check("beq_taken", taken, 1'b1);
        check("beq_target", target, 32'd92);
        check("beq_redirect", redirect_pc, 32'd92);
        check("beq_misp", mispredict, 1'b1);
        in_valid = 1'b0;
        tick();
        check("beq_drain", out_valid, 1'b0);
        look("beq_bht_trained", 32'd100, 1'b1);

        // Backpressure
        out_ready = 1'b0;
        issue(3'b001, 32'd1, 32'd2, 32'h300, 32'd4, 1'b0);
        tick();
        issue(3'b101, 32'd3, 32'd3, 32'h304, 32'h20, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_valid", out_valid, 1'b1);
            check("bp_taken", taken, 1'b1);
            check("bp_target", target, 32'h304);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        tick();
        check("bp_bge_taken", taken, 1'b1);
        check("bp_bge_target", target, 32'h324);
        check("bp_bge_misp", mispredict, 1'b0);
        issue(3'b111, 32'd0, 32'd1, 32'h308, 32'd8, 1'b0);
        tick();
        check("bp_bgeu_valid", out_valid, 1'b1);
        check("bp_bgeu_taken", taken, 1'b0);
        check("bp_bgeu_redirect", redirect_pc, 32'h30C);
        in_valid = 1'b0;
        tick();
        check("bp_drain", out_valid, 1'b0);

        // Reset mid-transfer with a held result
        out_ready = 1'b0;
        issue(3'b000, 32'd0, 32'd0, 32'h40, 32'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        do_reset();
        check("post_rst_ready", in_ready, 1'b1);
        look("post_rst_lookup", 32'd100, 1'b0);

        // BHT training at pc 0x40
        out_ready = 1'b1;
        issue(3'b000, 32'd0, 32'd0, 32'h40, 32'd0, 1'b0);
        tick();
        look("bht_before_commit", 32'h40, 1'b0);
        tick();
        look("bht_after_1", 32'h40, 1'b1);
        look("bht_alias_140", 32'h140, 1'b1);
        tick();
        tick();
        issue(3'b001, 32'd7, 32'd7, 32'h40, 32'd0, 1'b0);
        tick();
        tick();
        look("bht_sat_dec1", 32'h40, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        look("bht_sat_dec2", 32'h40, 1'b0);

        // Illegal op and flush, from a clean table
        do_reset();
        issue(3'b000, 32'd1, 32'd1, 32'h80, 32'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        look("flush_setup", 32'h80, 1'b1);
        issue(3'b010, 32'd1, 32'd1, 32'h80, 32'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("ill_taken", taken, 1'b0);
        check("ill_flag", illegal_op, 1'b1);
        check("ill_misp", mispredict, 1'b1);
        tick();
        look("ill_no_bht", 32'h80, 1'b1);
        issue(3'b001, 32'd9, 32'd9, 32'h80, 32'd0, 1'b0);
        tick();
        check("fl_captured", out_valid, 1'b1);
        issue(3'b000, 32'd2, 32'd2, 32'h80, 32'd0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 1'b0);
        tick();
        check("fl_dropped", out_valid, 1'b0);
        look("fl_no_bht", 32'h80, 1'b1);
`ifdef BRANCH_PERF_EN
        check("fl_perf_res", perf_resolved, 32'd2);
        check("fl_perf_mis", perf_mispredict, 32'd2);
`else
        check("fl_perf_res", perf_resolved, 32'd0);
        check("fl_perf_mis", perf_mispredict, 32'd0);
`endif

        // Wraparound and perf counting: 5 commits, 2 mispredicts
        do_reset();
        issue(3'b001, 32'd4, 32'd4, 32'hFFFF_FFFC, 32'd8, 1'b0);
        tick();
        check("wrap_redirect", redirect_pc, 32'h0);
        check("wrap_target", target, 32'h4);
        check("wrap_misp", mispredict, 1'b0);
        issue(3'b000, 32'd4, 32'd4, 32'h10, 32'd4, 1'b0);
        tick();
        issue(3'b000, 32'd4, 32'd4, 32'h14, 32'd4, 1'b1);
        tick();
        issue(3'b001, 32'd4, 32'd5, 32'h18, 32'd4, 1'b0);
        tick();
        issue(3'b011, 32'd4, 32'd5, 32'h1C, 32'd4, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("perf_drain", out_valid, 1'b0);
`ifdef BRANCH_PERF_EN
        check("perf_resolved", perf_resolved, 32'd5);
        check("perf_mispredict", perf_mispredict, 32'd2);
`else
        check("perf_resolved", perf_resolved, 32'd0);
        check("perf_mispredict", perf_mispredict, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
